// File: rtl/rx_buf_ctrl_pkg.sv
// rx_buf_ctrl shared definitions.
// FSM state encoding and default build parameters.
package rx_buf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } rx_state_e;

  localparam int unsigned AD_DEF     = 14;
  localparam int unsigned DATA_DEF   = 12;
  localparam int unsigned MEM_DEF    = 8000;
  localparam int unsigned THRESH_DEF = 64;

endpackage

// File: rtl/rx_wrap_ptr.sv
// Modulo-MEM pointer with clear and increment.
// Ports: clk, reset (async active-low), clr, inc -> ptr.
module rx_wrap_ptr #(
  parameter int unsigned AD  = 14,
  parameter int unsigned MEM = 8000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [AD-1:0] ptr
);

  localparam logic [AD-1:0] LAST = AD'(MEM - 1);
  localparam logic [AD-1:0] ONE  = AD'(1);

  logic [AD-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rx_buf_ctrl.sv
// RX sample RAM frame controller: circular write, threshold-gated reads.
// Ports: start/abort/frame_len, ADC in, RAM wr/rd, demod out, status.
module rx_buf_ctrl
  import rx_buf_ctrl_pkg::*;
#(
  parameter int unsigned AD     = AD_DEF,
  parameter int unsigned DATA   = DATA_DEF,
  parameter int unsigned MEM    = MEM_DEF,
  parameter int unsigned THRESH = THRESH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [AD-1:0]   frame_len,
  input  logic            adc_valid,
  input  logic [DATA-1:0] adc_data,
  output logic            ram_we,
  output logic [AD-1:0]   ram_waddr,
  output logic [DATA-1:0] ram_wdata,
  output logic            ram_re,
  output logic [AD-1:0]   ram_raddr,
  input  logic [DATA-1:0] ram_rdata,
  input  logic            dmd_ready,
  output logic            dmd_valid,
  output logic [DATA-1:0] dmd_data,
  output logic            dmd_last,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [AD:0]     occupancy
);

  localparam logic [AD:0]   MEM_W = (AD+1)'(MEM);
  localparam logic [AD:0]   THR_W = (AD+1)'(THRESH);
  localparam logic [AD:0]   OCC1  = (AD+1)'(1);
  localparam logic [AD-1:0] ONE   = AD'(1);

  rx_state_e     state_d, state_q;
  logic [AD-1:0] len_d, len_q;
  logic [AD-1:0] wr_d, wr_q;
  logic [AD-1:0] rd_d, rd_q;
  logic [AD:0]   occ_d, occ_q;
  logic          ovf_d, ovf_q;
  logic          vld_d, vld_q;
  logic          last_d, last_q;
  logic          done_d, done_q;

  logic active, start_ok, wr_want;
  logic we, re, drop, rd_final, clr_ptr;

  assign active = (state_q == ST_FILL)
               || (state_q == ST_STREAM);
  assign start_ok = (state_q == ST_IDLE) && start
                 && (frame_len != '0) && !abort;
  assign wr_want = active && !abort && adc_valid
                && (wr_q < len_q);
  assign we   = wr_want && (occ_q < MEM_W);
  assign drop = wr_want && (occ_q >= MEM_W);
  assign re   = (state_q == ST_STREAM) && !abort
             && dmd_ready && (occ_q != '0)
             && (rd_q < len_q);
  assign rd_final = ((rd_q + ONE) == len_q);
  assign clr_ptr  = start_ok || abort;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    occ_d   = occ_q;
    ovf_d   = ovf_q;
    vld_d   = re;
    last_d  = re && rd_final;
    done_d  = 1'b0;
    if (we) wr_d = wr_q + ONE;
    if (re) rd_d = rd_q + ONE;
    if (we && !re)      occ_d = occ_q + OCC1;
    else if (re && !we) occ_d = occ_q - OCC1;
    if (drop) ovf_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_FILL;
          len_d   = frame_len;
          wr_d    = '0;
          rd_d    = '0;
          occ_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_FILL: begin
        if (occ_q >= THR_W || wr_q == len_q)
          state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (re && rd_final) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort drops the in-flight sample and any pending done.
    if (abort) begin
      state_d = ST_IDLE;
      occ_d   = '0;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  rx_wrap_ptr #(.AD(AD), .MEM(MEM)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_ptr),
    .inc   (we),
    .ptr   (ram_waddr)
  );

  rx_wrap_ptr #(.AD(AD), .MEM(MEM)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_ptr),
    .inc   (re),
    .ptr   (ram_raddr)
  );

  assign ram_we    = we;
  assign ram_wdata = adc_data;
  assign ram_re    = re;
  assign dmd_valid = vld_q;
  assign dmd_data  = ram_rdata;
  assign dmd_last  = last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign occupancy = occ_q;

endmodule
